// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control FSM.
// The ADDIEX/ADDIWB path only exists when MC_ADDI_EN is defined.
package mc_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdest;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_out_decode.sv
// Combinational Moore output decode: {state, mem_ready} -> control vector.
// ADDIEX/ADDIWB outputs are decoded only when MC_ADDI_EN is defined.
module mc_out_decode
  import mc_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.memread = 1'b1;
        ctrl_o.alusrcb = SRCB_FOUR;
        ctrl_o.irwrite = mem_ready_i;
        ctrl_o.pcwrite = mem_ready_i;
      end
      S_DECODE: ctrl_o.alusrcb = SRCB_IMMSH;
      S_MEMADR: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl_o.memread = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.memwrite   = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      S_MEMWB: begin
        ctrl_o.memtoreg   = 1'b1;
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl_o.regdest    = 1'b1;
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alusrca     = 1'b1;
        ctrl_o.aluop       = ALUOP_SUB;
        ctrl_o.pcwritecond = 1'b1;
        ctrl_o.pcsource    = PCSRC_ALUOUT;
        ctrl_o.instr_done  = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pcwrite    = 1'b1;
        ctrl_o.pcsource   = PCSRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
`ifdef MC_ADDI_EN
      S_ADDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
`endif
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, next-state logic, reset gating.
// Define MC_ADDI_EN to make opcode 001000 (addi) legal.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdest,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  logic [3:0] state_q, state_d;
  logic       illegal_d;
  ctrl_t      ctrl;

  // mem_ready handshake: in FETCH/MEMRD/MEMWR the access completes in a cycle
  // where mem_ready=1; until then the FSM holds and the strobes stay constant.
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default:      illegal_d = 1'b1;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
      end
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RWB;
`ifdef MC_ADDI_EN
      S_ADDIEX: state_d = S_ADDIWB;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  mc_out_decode u_out_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  // Every output, including the debug state, reads as 0 while rst is high.
  assign pcwrite     = ~rst & ctrl.pcwrite;
  assign pcwritecond = ~rst & ctrl.pcwritecond;
  assign iord        = ~rst & ctrl.iord;
  assign memread     = ~rst & ctrl.memread;
  assign memwrite    = ~rst & ctrl.memwrite;
  assign irwrite     = ~rst & ctrl.irwrite;
  assign memtoreg    = ~rst & ctrl.memtoreg;
  assign regdest     = ~rst & ctrl.regdest;
  assign regwrite    = ~rst & ctrl.regwrite;
  assign alusrca     = ~rst & ctrl.alusrca;
  assign alusrcb     = rst ? 2'b00 : ctrl.alusrcb;
  assign aluop       = rst ? 2'b00 : ctrl.aluop;
  assign pcsource    = rst ? 2'b00 : ctrl.pcsource;
  assign state       = rst ? S_FETCH : state_q;
  assign instr_done  = ~rst & ctrl.instr_done;
  assign illegal_op  = ~rst & illegal_d;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction state paths and
// strobe counts derived from the instruction-level behaviour.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdest, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsource;
  logic [3:0] state;
  logic       instr_done, illegal_op;

  int checks   = 0;
  int failures = 0;

  localparam logic [3:0] T_FETCH = 4'd0, T_DECODE = 4'd1, T_MEMADR = 4'd2,
                         T_MEMRD = 4'd3, T_MEMWB = 4'd4, T_MEMWR = 4'd5,
                         T_EXEC = 4'd6, T_RWB = 4'd7, T_BRANCH = 4'd8,
                         T_JUMP = 4'd9, T_ADDIEX = 4'd10, T_ADDIWB = 4'd11;

`ifdef MC_ADDI_EN
  localparam bit ADDI_LEGAL = 1'b1;
`else
  localparam bit ADDI_LEGAL = 1'b0;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .pcwrite     (pcwrite),
    .pcwritecond (pcwritecond),
    .iord        (iord),
    .memread     (memread),
    .memwrite    (memwrite),
    .irwrite     (irwrite),
    .memtoreg    (memtoreg),
    .regdest     (regdest),
    .regwrite    (regwrite),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .aluop       (aluop),
    .pcsource    (pcsource),
    .state       (state),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op)
  );

  wire [21:0] out_vec = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                         memtoreg, regdest, regwrite, alusrca, alusrcb, aluop,
                         pcsource, state, instr_done, illegal_op};

  localparam logic [21:0] FETCH_READY_VEC =
    {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
     2'b01, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0};

  function automatic bit is_legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010: return 1'b1;
      6'b001000: return ADDI_LEGAL;
      default:   return 1'b0;
    endcase
  endfunction

  // Runs one instruction from FETCH back to FETCH; fw/mw = wait cycles in
  // FETCH and in the data-memory access. Starts and ends just after a negedge.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input string name);
    logic [3:0] exp_q[$];
    bit         rdy_q[$];
    bit         legal, is_lw, is_sw, is_r, is_beq, is_j, is_addi;
    int         got_a[15], exp_a[15];
    string      nm[15];
    int         done_idx, ill_idx, n;
    legal   = is_legal(op);
    is_lw   = legal && op == 6'b100011;
    is_sw   = legal && op == 6'b101011;
    is_r    = legal && op == 6'b000000;
    is_beq  = legal && op == 6'b000100;
    is_j    = legal && op == 6'b000010;
    is_addi = legal && op == 6'b001000;
    for (int i = 0; i < fw; i++) begin exp_q.push_back(T_FETCH); rdy_q.push_back(1'b0); end
    exp_q.push_back(T_FETCH);  rdy_q.push_back(1'b1);
    exp_q.push_back(T_DECODE); rdy_q.push_back(1'($urandom_range(0, 1)));
    if (is_lw || is_sw) begin
      exp_q.push_back(T_MEMADR); rdy_q.push_back(1'($urandom_range(0, 1)));
      for (int i = 0; i <= mw; i++) begin
        exp_q.push_back(is_lw ? T_MEMRD : T_MEMWR);
        rdy_q.push_back(i == mw);
      end
      if (is_lw) begin exp_q.push_back(T_MEMWB); rdy_q.push_back(1'($urandom_range(0, 1))); end
    end else if (is_r) begin
      exp_q.push_back(T_EXEC); rdy_q.push_back(1'($urandom_range(0, 1)));
      exp_q.push_back(T_RWB);  rdy_q.push_back(1'($urandom_range(0, 1)));
    end else if (is_beq) begin
      exp_q.push_back(T_BRANCH); rdy_q.push_back(1'($urandom_range(0, 1)));
    end else if (is_j) begin
      exp_q.push_back(T_JUMP); rdy_q.push_back(1'($urandom_range(0, 1)));
    end else if (is_addi) begin
      exp_q.push_back(T_ADDIEX); rdy_q.push_back(1'($urandom_range(0, 1)));
      exp_q.push_back(T_ADDIWB); rdy_q.push_back(1'($urandom_range(0, 1)));
    end
    n = exp_q.size();
    foreach (got_a[k]) got_a[k] = 0;
    done_idx = -1;
    ill_idx  = -1;
    for (int i = 0; i < n; i++) begin
      rst       = 1'b0;
      mem_ready = rdy_q[i];
      opcode    = (i <= fw) ? 6'($urandom_range(0, 63)) : op;
      #1;
      checks++;
      if (state !== exp_q[i]) begin
        failures++;
        $display("FAIL %s state cycle %0d got=%0d exp=%0d", name, i, state, exp_q[i]);
      end
      checks++;
      if (instr_done === 1'b1 && illegal_op === 1'b1) begin
        failures++;
        $display("FAIL %s done_with_illegal cycle %0d got=1 exp=0", name, i);
      end
      if (exp_q[i] == T_ADDIWB) begin
        checks++;
        if (regdest !== 1'b0 || regwrite !== 1'b1) begin
          failures++;
          $display("FAIL %s addiwb regdest/regwrite got=%b%b exp=01", name, regdest, regwrite);
        end
      end
      got_a[0]  += int'(memread);
      got_a[1]  += int'(memwrite);
      got_a[2]  += int'(iord);
      got_a[3]  += int'(regwrite);
      got_a[4]  += int'(memtoreg);
      got_a[5]  += int'(regdest);
      got_a[6]  += int'(pcwrite);
      got_a[7]  += int'(irwrite);
      got_a[8]  += int'(pcwritecond);
      got_a[9]  += int'(pcsource == 2'b10);
      got_a[10] += int'(pcsource == 2'b01);
      got_a[11] += int'(instr_done);
      got_a[12] += int'(illegal_op);
      if (instr_done === 1'b1) done_idx = i;
      if (illegal_op === 1'b1) ill_idx  = i;
      @(negedge clk);
    end
    got_a[13] = done_idx;
    got_a[14] = ill_idx;
    nm = '{"memread", "memwrite", "iord", "regwrite", "memtoreg", "regdest",
           "pcwrite", "irwrite", "pcwritecond", "pcsrc_jump", "pcsrc_aluout",
           "done_count", "illegal_count", "done_cycle", "illegal_cycle"};
    exp_a[0]  = fw + 1 + (is_lw ? mw + 1 : 0);
    exp_a[1]  = is_sw ? mw + 1 : 0;
    exp_a[2]  = (is_lw || is_sw) ? mw + 1 : 0;
    exp_a[3]  = int'(is_r || is_lw || is_addi);
    exp_a[4]  = int'(is_lw);
    exp_a[5]  = int'(is_r);
    exp_a[6]  = 1 + int'(is_j);
    exp_a[7]  = 1;
    exp_a[8]  = int'(is_beq);
    exp_a[9]  = int'(is_j);
    exp_a[10] = int'(is_beq);
    exp_a[11] = int'(legal);
    exp_a[12] = int'(!legal);
    exp_a[13] = legal ? n - 1 : -1;
    exp_a[14] = legal ? -1 : fw + 1;
    for (int k = 0; k < 15; k++) begin
      checks++;
      if (got_a[k] !== exp_a[k]) begin
        failures++;
        $display("FAIL %s %s got=%0d exp=%0d", name, nm[k], got_a[k], exp_a[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    mem_ready = 1'b1;
    opcode    = 6'($urandom_range(0, 63));
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out_vec !== 22'd0) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d got=%h exp=0", i, out_vec);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (out_vec !== FETCH_READY_VEC) begin
      failures++;
      $display("FAIL first_fetch got=%h exp=%h", out_vec, FETCH_READY_VEC);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_vec !== 22'd0) begin
      failures++;
      $display("FAIL reset_in_decode got=%h exp=0", out_vec);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_s[4];
    bit         rdy_s[4];
    exp_s = '{T_FETCH, T_DECODE, T_MEMADR, T_MEMRD};
    rdy_s = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      rst       = 1'b0;
      mem_ready = rdy_s[i];
      opcode    = 6'b100011;
      #1;
      checks++;
      if (state !== exp_s[i]) begin
        failures++;
        $display("FAIL reset_mid path cycle %0d got=%0d exp=%0d", i, state, exp_s[i]);
      end
      @(negedge clk);
    end
    rst       = 1'b1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (out_vec !== 22'd0) begin
      failures++;
      $display("FAIL reset_mid strobes got=%h exp=0", out_vec);
    end
    @(negedge clk);
    rst       = 1'b0;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== T_FETCH || regwrite !== 1'b0 || memread !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid resume state=%0d regwrite=%b memread=%b exp=0/0/1",
               state, regwrite, memread);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [5:0] pool[8];
    pool = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
             6'b001000, 6'b111111, 6'b000000};
    for (int t = 0; t < 40; t++) begin
      logic [5:0] op;
      op = pool[$urandom_range(0, 7)];
      if (t % 5 == 4) op = 6'($urandom_range(0, 63));
      run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    test_reset();
    run_instr(6'b100011, 0, 0, "lw");
    run_instr(6'b101011, 0, 2, "sw_wait");
    run_instr(6'b000000, 0, 0, "rtype");
    run_instr(6'b000100, 0, 0, "beq");
    run_instr(6'b000010, 0, 0, "jump");
    run_instr(6'b111111, 0, 0, "illegal");
    run_instr(6'b001000, 0, 0, "addi");
    run_instr(6'b100011, 2, 1, "lw_waits");
    test_reset_mid();
    test_random();
    checks++;
    #1;
    if (state !== T_FETCH) begin
      failures++;
      $display("FAIL final_state got=%0d exp=0", state);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
